eth_tx_frame_scheduler: RTL and testbench
=========================================

# eth_tx_frame_scheduler

Shares the single Ethernet MAC transmit byte path between `num_req_p` frame sources. Round-robin arbitration runs per frame, never per byte. Each granted frame is wrapped with preamble and SFD, and an inter-frame gap is enforced between frames. The block sits upstream of the CRC/FCS append stage and the RGMII TX serializer. The downstream `tx_ready_i` absorbs 10/100/1000 pacing, so this block is speed-agnostic.

## Interface
- `num_req_p`, 2: number of requesters, 2..8.
- `ifg_bytes_p`, 12: inter-frame gap, in accepted byte slots.
- `max_payload_p`, 1514: maximum payload bytes per frame (DA+SA+type+data).
- `clk_i` in 1: single clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `req_v_i` in `num_req_p`: requester byte valid.
- `req_data_i` in `num_req_p`x8: requester payload bytes.
- `req_last_i` in `num_req_p`: marks the final payload byte of a frame.
- `req_yumi_o` out `num_req_p`: byte consumed this cycle.
- `tx_v_o` out 1: output byte valid.
- `tx_data_o` out 8: output byte.
- `tx_sof_o` out 1: first preamble byte.
- `tx_last_o` out 1: final byte of the frame.
- `tx_ready_i` in 1: downstream accepts the byte (`tx_v_o & tx_ready_i` = transfer).
- `grant_o` out clog2(`num_req_p`): current/last granted requester.
- `busy_o` out 1: state is not IDLE.
- `oversize_o` out 1: one-cycle pulse when a frame is truncated.

## Operation
- States and transitions:
  - IDLE → PRE when any `req_v_i` is set.
  - PRE: 7 bytes of 0x55, then → SFD.
  - SFD: 0xD5, then → PAY.
  - PAY → IFG, or → PAD (`ETH_TX_PAD_EN` only), or → DRAIN on oversize.
  - PAD → IFG.
  - DRAIN → IFG.
  - IFG → IDLE.
- Arbitration happens in IDLE only. The winner is the first valid requester scanning upward from `grant_o`+1, wrapping modulo `num_req_p`. The winner is registered into `grant_o` on the IDLE→PRE edge and held until the next arbitration.
- PRE/SFD: `tx_v_o`=1 and the byte is a constant. The byte counter advances only on transfer. `tx_sof_o`=1 on the first PRE byte.
- PAY:
  - `tx_v_o` = `req_v_i[grant]`, `tx_data_o` = `req_data_i[grant]`.
  - `req_yumi_o[grant]` = `req_v_i[grant] & tx_ready_i`. All other yumi bits are 0 in every state except DRAIN.
  - An 11-bit payload counter increments per transfer and saturates.
- Normal end: a transfer with `req_last_i[grant]` sets `tx_last_o` on that byte → IFG.
- Oversize: on the transfer of byte number `max_payload_p` without `req_last_i`:
  - `tx_last_o` is forced on that byte and `oversize_o` pulses.
  - → DRAIN. In DRAIN, `tx_v_o`=0 and `req_yumi_o[grant]` = `req_v_i[grant]`, discarding bytes until a consumed byte has last → IFG.
- IFG: `tx_v_o`=0. A counter decrements from `ifg_bytes_p` once per `tx_ready_i` cycle. At 0 → IDLE.
- Simultaneous events:
  - Last byte arriving exactly at `max_payload_p` is a normal end: no pulse, no DRAIN.
  - A requester dropping valid mid-frame stalls the frame; the grant is never switched.
- Reset mid-frame: return to IDLE at once; the partial frame is abandoned downstream.

## Timing
- Reset values:
  - state=IDLE, `grant_o` = `num_req_p`-1 (so requester 0 wins first).
  - All counters 0.
  - `tx_v_o`, `tx_sof_o`, `tx_last_o`, `req_yumi_o`, `busy_o`, `oversize_o` = 0; `tx_data_o` = 0.
- Latency:
  - Requester valid in IDLE → first PRE byte with `tx_v_o` on the next cycle.
  - Payload is combinational pass-through (0 cycles).
- Back-to-back frames with `tx_ready_i` held at 1: minimum of 8 + payload + `ifg_bytes_p` + 1 (IDLE) cycles per frame.
- All outputs are decoded from registered state/counters, except the PAY-state pass-through terms.

## Configuration
- `ETH_TX_PAD_EN` defined:
  - If last arrives with payload count < 60, `tx_last_o` is suppressed on that byte → PAD.
  - PAD emits 0x00 until the count reaches 60, with `tx_last_o` on the 60th byte → IFG.
- Undefined: the PAD state is not built; short frames pass unpadded.

## Structure
- Shared package `eth_tx_pkg` holds:
  - the state enum;
  - constants `eth_preamble_byte`=0x55, `eth_sfd_byte`=0xD5, `eth_min_payload`=60, `eth_preamble_len`=7.
- One sub-module, `eth_tx_rr_arbiter`: combinational round-robin winner from the request vector and last grant, with a one-hot/encoded output.

## Test plan
- Single frame, req0, 64 bytes 0x00..0x3F, ready=1 → 7×0x55, 0xD5, 64 bytes, last on 0x3F, then exactly 12 idle cycles.
- Both requesters continuously valid with 3 frames each → grants strictly alternate 0,1,0,1,0,1, and no byte interleaving within a frame.
- `tx_ready_i` toggled pseudo-randomly at 50% → byte sequence identical to the ready=1 case; IFG counts 12 ready cycles.
- 1520-byte frame without early last → 1514 bytes out, last on byte 1514, `oversize_o` one pulse, remaining 6 bytes yumi'd with `tx_v_o`=0.
- `ETH_TX_PAD_EN`, 20-byte frame → 20 data bytes + 40×0x00, last on byte 60. Without the macro → last on byte 20.
- Reset asserted during PAY byte 30 → all outputs 0 immediately; next frame starts with a fresh preamble, and requester 0 wins.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared state encoding and framing constants for the Ethernet TX frame scheduler.
// The PAD state exists only when ETH_TX_PAD_EN is defined.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_PAY,
    ST_DRAIN,
    ST_IFG
`ifdef ETH_TX_PAD_EN
    , ST_PAD
`endif
  } state_t;

  localparam logic [7:0] eth_preamble_byte = 8'h55;
  localparam logic [7:0] eth_sfd_byte      = 8'hD5;
  localparam int         eth_min_payload   = 60;
  localparam int         eth_preamble_len  = 7;

endpackage

// File: rtl/eth_tx_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester above last_grant, wrapping.
// Module name is eth_tx_rr_arbiter; one-hot and encoded winner are both provided.
module eth_tx_rr_arbiter #(
  parameter int num_req_p = 2,
  parameter int grant_w_p = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic [num_req_p-1:0] req,
  input  logic [grant_w_p-1:0] last_grant,
  output logic [num_req_p-1:0] grant_oh,
  output logic [grant_w_p-1:0] grant_idx
);

  logic found;

  always_comb begin
    grant_oh  = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    for (int i = 1; i <= num_req_p; i++) begin
      for (int j = 0; j < num_req_p; j++) begin
        if (!found && req[j] && (j == ((int'(last_grant) + i) % num_req_p))) begin
          found       = 1'b1;
          grant_oh[j] = 1'b1;
          grant_idx   = grant_w_p'(j);
        end
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_scheduler.sv
// Frame-level round-robin scheduler onto the MAC TX byte path: adds preamble/SFD,
// truncates oversize frames, enforces the IFG. ETH_TX_PAD_EN adds short-frame padding.
//   state | meaning
//   IDLE  | arbitrate among valid requesters
//   PRE   | 7 x 0x55 preamble
//   SFD   | 0xD5 start-of-frame delimiter
//   PAY   | pass-through of granted requester bytes
//   PAD   | zero fill up to the minimum payload (ETH_TX_PAD_EN)
//   DRAIN | discard remainder of a truncated frame
//   IFG   | inter-frame gap, counted in ready cycles
module eth_tx_frame_scheduler
  import eth_tx_pkg::*;
#(
  parameter int num_req_p     = 2,
  parameter int ifg_bytes_p   = 12,
  parameter int max_payload_p = 1514,
  parameter int grant_w_p     = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [num_req_p-1:0]      req_v_i,
  input  logic [num_req_p-1:0][7:0] req_data_i,
  input  logic [num_req_p-1:0]      req_last_i,
  output logic [num_req_p-1:0]      req_yumi_o,
  output logic                      tx_v_o,
  output logic [7:0]                tx_data_o,
  output logic                      tx_sof_o,
  output logic                      tx_last_o,
  input  logic                      tx_ready_i,
  output logic [grant_w_p-1:0]      grant_o,
  output logic                      busy_o,
  output logic                      oversize_o
);

  localparam int              ifg_w    = $clog2(ifg_bytes_p + 1);
  localparam logic [ifg_w-1:0] ifg_load = ifg_w'(ifg_bytes_p);
  localparam logic [10:0]     pay_max  = 11'(max_payload_p);
  localparam logic [10:0]     pre_last = 11'(eth_preamble_len - 1);
`ifdef ETH_TX_PAD_EN
  localparam logic [10:0]     pay_min  = 11'(eth_min_payload);
`endif

  state_t               state_r, state_n;
  logic [10:0]          cnt_r, cnt_n, cnt_inc;
  logic [ifg_w-1:0]     ifg_r, ifg_n;
  logic [grant_w_p-1:0] grant_r, grant_n;
  logic [num_req_p-1:0] arb_oh;
  logic [grant_w_p-1:0] arb_idx;
  logic                 g_v, g_last, xfer;

  eth_tx_rr_arbiter #(
    .num_req_p (num_req_p),
    .grant_w_p (grant_w_p)
  ) u_arb (
    .req        (req_v_i),
    .last_grant (grant_r),
    .grant_oh   (arb_oh),
    .grant_idx  (arb_idx)
  );

  assign g_v     = req_v_i[grant_r];
  assign g_last  = req_last_i[grant_r];
  assign cnt_inc = (cnt_r == 11'h7FF) ? cnt_r : cnt_r + 11'd1;
  assign grant_o = grant_r;
  assign busy_o  = (state_r != ST_IDLE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      ifg_r   <= '0;
      grant_r <= grant_w_p'(num_req_p - 1);
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      ifg_r   <= ifg_n;
      grant_r <= grant_n;
    end
  end

  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    ifg_n      = ifg_r;
    grant_n    = grant_r;
    tx_v_o     = 1'b0;
    tx_data_o  = 8'h00;
    tx_sof_o   = 1'b0;
    tx_last_o  = 1'b0;
    req_yumi_o = '0;
    oversize_o = 1'b0;
    xfer       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_n = '0;
        if (|arb_oh) begin
          grant_n = arb_idx;
          state_n = ST_PRE;
        end
      end
      ST_PRE: begin
        tx_v_o    = 1'b1;
        tx_data_o = eth_preamble_byte;
        tx_sof_o  = (cnt_r == '0);
        if (tx_ready_i) begin
          if (cnt_r == pre_last) begin
            cnt_n   = '0;
            state_n = ST_SFD;
          end else begin
            cnt_n = cnt_r + 11'd1;
          end
        end
      end
      ST_SFD: begin
        tx_v_o    = 1'b1;
        tx_data_o = eth_sfd_byte;
        if (tx_ready_i) begin
          cnt_n   = '0;
          state_n = ST_PAY;
        end
      end
      ST_PAY: begin
        tx_v_o              = g_v;
        tx_data_o           = req_data_i[grant_r];
        xfer                = g_v & tx_ready_i;
        req_yumi_o[grant_r] = xfer;
        if (xfer) begin
          cnt_n = cnt_inc;
          if (g_last) begin
`ifdef ETH_TX_PAD_EN
            if (cnt_inc < pay_min) begin
              state_n = ST_PAD;
            end else begin
              tx_last_o = 1'b1;
              ifg_n     = ifg_load;
              state_n   = ST_IFG;
            end
`else
            tx_last_o = 1'b1;
            ifg_n     = ifg_load;
            state_n   = ST_IFG;
`endif
          end else if (cnt_inc == pay_max) begin
            // last arriving on the limit byte is a normal end, handled above
            tx_last_o  = 1'b1;
            oversize_o = 1'b1;
            state_n    = ST_DRAIN;
          end
        end
      end
`ifdef ETH_TX_PAD_EN
      ST_PAD: begin
        tx_v_o = 1'b1;
        if (tx_ready_i) begin
          cnt_n = cnt_inc;
          if (cnt_inc == pay_min) begin
            tx_last_o = 1'b1;
            ifg_n     = ifg_load;
            state_n   = ST_IFG;
          end
        end
      end
`endif
      ST_DRAIN: begin
        req_yumi_o[grant_r] = g_v;
        if (g_v && g_last) begin
          ifg_n   = ifg_load;
          state_n = ST_IFG;
        end
      end
      ST_IFG: begin
        if (tx_ready_i) begin
          if (ifg_r <= ifg_w'(1)) begin
            ifg_n   = '0;
            state_n = ST_IDLE;
          end else begin
            ifg_n = ifg_r - ifg_w'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_tx_frame_scheduler.sv
// Scoreboard bench for eth_tx_frame_scheduler: frames are queued per requester with
// their expected output bytes; a negedge monitor pops and compares every transfer.
module tb_eth_tx_frame_scheduler;

  localparam int N   = 2;
  localparam int IFG = 12;
  localparam bit pad_en =
`ifdef ETH_TX_PAD_EN
    1'b1;
`else
    1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [N-1:0]      req_v_i;
  logic [N-1:0][7:0] req_data_i;
  logic [N-1:0]      req_last_i;
  logic [N-1:0]      req_yumi_o;
  logic              tx_v_o;
  logic [7:0]        tx_data_o;
  logic              tx_sof_o;
  logic              tx_last_o;
  logic              tx_ready_i;
  logic [0:0]        grant_o;
  logic              busy_o;
  logic              oversize_o;

  eth_tx_frame_scheduler #(
    .num_req_p     (N),
    .ifg_bytes_p   (IFG),
    .max_payload_p (1514)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .req_v_i    (req_v_i),
    .req_data_i (req_data_i),
    .req_last_i (req_last_i),
    .req_yumi_o (req_yumi_o),
    .tx_v_o     (tx_v_o),
    .tx_data_o  (tx_data_o),
    .tx_sof_o   (tx_sof_o),
    .tx_last_o  (tx_last_o),
    .tx_ready_i (tx_ready_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .oversize_o (oversize_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       last;
    logic [0:0] gnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] src0[$];   // {bubble, last, data}
  logic [9:0] src1[$];
  int         errors = 0;
  int         checks = 0;
  int         ovs_cnt = 0;
  bit         rnd_ready = 1'b0;
  logic [N-1:0] pres_bub;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_src(input int r, input logic [9:0] e);
    if (r == 0) src0.push_back(e);
    else        src1.push_back(e);
  endtask

  // n_exp payload bytes are expected out; abort frames carry no last and no pad.
  task automatic add_frame(input int r, input int len, input logic [7:0] base, input int n_exp,
                           input logic [0:0] gnt, input int bub_at, input bit abort);
    int   total;
    exp_t e;
    for (int i = 0; i < len; i++) begin
      if (i == bub_at) push_src(r, 10'h200);
      push_src(r, {1'b0, (i == len - 1), 8'(base + i)});
    end
    total = n_exp;
    if (pad_en && !abort && n_exp < 60) total = 60;
    for (int i = 0; i < 7; i++) begin
      e = '{data: 8'h55, sof: (i == 0), last: 1'b0, gnt: gnt};
      exp_q.push_back(e);
    end
    e = '{data: 8'hD5, sof: 1'b0, last: 1'b0, gnt: gnt};
    exp_q.push_back(e);
    for (int i = 0; i < total; i++) begin
      e = '{data: (i < n_exp) ? 8'(base + i) : 8'h00, sof: 1'b0,
            last: !abort && (i == total - 1), gnt: gnt};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src0.size() != 0 || src1.size() != 0 || busy_o) && n < budget) begin
      @(negedge clk_i);
      #2;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: %0d expected bytes left, busy=%0b", name, exp_q.size(), busy_o);
      exp_q.delete();
      src0.delete();
      src1.delete();
    end
  endtask

  // requester driver: yumi sampled at negedge, queue advanced just after posedge
  initial begin
    logic [N-1:0] y;
    req_v_i    = '0;
    req_data_i = '0;
    req_last_i = '0;
    tx_ready_i = 1'b1;
    pres_bub   = '0;
    forever begin
      @(negedge clk_i);
      y = req_yumi_o;
      @(posedge clk_i);
      #1;
      if ((y[0] || pres_bub[0]) && src0.size() > 0) void'(src0.pop_front());
      if ((y[1] || pres_bub[1]) && src1.size() > 0) void'(src1.pop_front());
      req_v_i  = '0;
      pres_bub = '0;
      if (src0.size() > 0) begin
        req_v_i[0]    = ~src0[0][9];
        pres_bub[0]   = src0[0][9];
        req_last_i[0] = src0[0][8];
        req_data_i[0] = src0[0][7:0];
      end
      if (src1.size() > 0) begin
        req_v_i[1]    = ~src1[0][9];
        pres_bub[1]   = src1[0][9];
        req_last_i[1] = src1[0][8];
        req_data_i[1] = src1[0][7:0];
      end
      tx_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: compares every transfer and measures the gap after each last byte
  initial begin
    exp_t e;
    int   gap;
    bit   in_gap;
    gap    = 0;
    in_gap = 1'b0;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        in_gap = 1'b0;
      end else begin
        if (oversize_o) ovs_cnt++;
        if (tx_v_o && tx_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got 0x%0h expected no transfer at %0t", tx_data_o, $time);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data_o), 32'(e.data));
            check("tx_sof", 32'(tx_sof_o), 32'(e.sof));
            check("tx_last", 32'(tx_last_o), 32'(e.last));
            if (e.sof) check("grant", 32'(grant_o), 32'(e.gnt));
            if (tx_last_o) begin
              in_gap = 1'b1;
              gap    = 0;
            end
          end
        end else if (in_gap) begin
          if (busy_o) begin
            if (tx_ready_i && req_yumi_o == '0) gap++;
          end else begin
            check("ifg_ready_cycles", 32'(gap), 32'(IFG));
            in_gap = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int budget;
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #2;
    check("rst_tx_v", 32'(tx_v_o), 0);
    check("rst_tx_data", 32'(tx_data_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_yumi", 32'(req_yumi_o), 0);
    check("rst_grant", 32'(grant_o), 1);
    @(negedge clk_i);
    reset_i = 1'b0;

    // both requesters backlogged: strict alternation, req0 stalls once mid-frame
    add_frame(0, 16, 8'h80, 16, 1'b0, -1, 1'b0);
    add_frame(1, 16, 8'hA0, 16, 1'b1, -1, 1'b0);
    add_frame(0, 16, 8'h10, 16, 1'b0, 5, 1'b0);
    add_frame(1, 16, 8'hB0, 16, 1'b1, -1, 1'b0);
    add_frame(0, 16, 8'h20, 16, 1'b0, -1, 1'b0);
    add_frame(1, 16, 8'hC0, 16, 1'b1, -1, 1'b0);
    wait_done("alternate", 1500);

    // single 64-byte frame from req0
    add_frame(0, 64, 8'h00, 64, 1'b0, -1, 1'b0);
    wait_done("single", 400);

    // same frame under random ready
    rnd_ready = 1'b1;
    add_frame(1, 64, 8'h00, 64, 1'b1, -1, 1'b0);
    wait_done("random_ready", 1500);
    rnd_ready = 1'b0;

    // 1520-byte frame truncated at 1514
    ovs_cnt = 0;
    add_frame(0, 1520, 8'h00, 1514, 1'b0, -1, 1'b0);
    wait_done("oversize", 3000);
    check("oversize_pulses", 32'(ovs_cnt), 1);
    check("oversize_drained", 32'(src0.size()), 0);

    // last exactly on the limit byte is a normal end
    ovs_cnt = 0;
    add_frame(1, 1514, 8'h33, 1514, 1'b1, -1, 1'b0);
    wait_done("exact_max", 3000);
    check("exact_max_no_pulse", 32'(ovs_cnt), 0);

    // short frame: padded to 60 only when the pad feature is built
    add_frame(0, 20, 8'h60, 20, 1'b0, -1, 1'b0);
    wait_done("short", 400);

    // reset while byte 30 of a frame is presented
    add_frame(1, 64, 8'h40, 29, 1'b1, -1, 1'b1);
    budget = 0;
    while (exp_q.size() != 0 && budget < 400) begin
      @(negedge clk_i);
      #2;
      budget++;
    end
    check("abort_reached", 32'(exp_q.size()), 0);
    @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    check("abort_tx_v", 32'(tx_v_o), 0);
    check("abort_tx_data", 32'(tx_data_o), 0);
    check("abort_sof_last", 32'({tx_sof_o, tx_last_o, oversize_o}), 0);
    check("abort_yumi", 32'(req_yumi_o), 0);
    check("abort_busy", 32'(busy_o), 0);
    src0.delete();
    src1.delete();
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    add_frame(0, 16, 8'hD0, 16, 1'b0, -1, 1'b0);
    add_frame(1, 16, 8'hE0, 16, 1'b1, -1, 1'b0);
    wait_done("after_reset", 600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
